mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single unified instruction/data RAM between the multi-cycle MIPS core (port 0) and a program-loader/debug master (port 1).
- Sits between the requesters and the RAM's Addr/Data/W_EN/sel/Output_Data pins.
- Serialises accesses through a two-state FSM and resolves contention by fixed priority with a starvation guard, or by round-robin.
- Registers each command, drives the RAM for exactly one cycle, and returns read data registered per port.

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//    Shares one combinational-read RAM between the MIPS core (port 0) and the
//    program-loader/debug master (port 1). Each access takes one IDLE cycle to
//    arbitrate and latch the command, then one ACCESS cycle that drives the RAM.
//    Read data is captured per port at the closing edge of ACCESS.
//
// Ports
//    CLK, RST                 clock, synchronous active-high reset
//    reqN/weN/selN/addrN/     port N command (N = 0, 1), held while reqN is high
//    wdataN
//    gntN                     port N access is on the RAM this cycle
//    rvalidN/rdataN           port N read data pulse / held read data
//    ram_addr/ram_wdata/      RAM command, from the latched command registers
//    ram_we/ram_sel
//    ram_rdata                RAM read data (combinational)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no RAM access; arbitrate and latch winner's command
// ACCESS | latched command drives the RAM; gnt[owner] high for one cycle

module mem_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int RR_MODE       = 0,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     req0,
   input  logic                     we0,
   input  logic [1:0]               sel0,
   input  logic [ADDRESS_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0]    wdata0,
   output logic                     gnt0,
   output logic                     rvalid0,
   output logic [DATA_WIDTH-1:0]    rdata0,
   input  logic                     req1,
   input  logic                     we1,
   input  logic [1:0]               sel1,
   input  logic [ADDRESS_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0]    wdata1,
   output logic                     gnt1,
   output logic                     rvalid1,
   output logic [DATA_WIDTH-1:0]    rdata1,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_wdata,
   output logic                     ram_we,
   output logic [1:0]               ram_sel,
   input  logic [DATA_WIDTH-1:0]    ram_rdata
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t                   state_q, state_d;
   logic                     owner_q, owner_d;
   logic                     last_owner_q, last_owner_d;
   logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
   logic                     cmd_we_q, cmd_we_d;
   logic [1:0]               cmd_sel_q, cmd_sel_d;
   logic [ADDRESS_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0]    cmd_wdata_q, cmd_wdata_d;
   logic                     rvalid0_q, rvalid0_d;
   logic                     rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
   logic                     pick;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      starve_cnt_d = starve_cnt_q;
      cmd_we_d     = cmd_we_q;
      cmd_sel_d    = cmd_sel_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      pick         = owner_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               if (req0 && req1) begin
                  if (RR_MODE != 0) begin
                     pick = ~last_owner_q;
                  end else if (starve_cnt_q == CNT_LIMIT) begin
                     pick = 1'b1;
                  end else begin
                     pick         = 1'b0;
                     starve_cnt_d = starve_cnt_q + CNT_ONE;
                  end
               end else begin
                  pick = req1;
               end

               // port 1 winning for any reason ends its losing streak
               if (pick) begin
                  starve_cnt_d = '0;
               end
               if (RR_MODE != 0) begin
                  starve_cnt_d = '0;
               end

               owner_d      = pick;
               last_owner_d = pick;
               cmd_we_d     = pick ? we1    : we0;
               cmd_sel_d    = pick ? sel1   : sel0;
               cmd_addr_d   = pick ? addr1  : addr0;
               cmd_wdata_d  = pick ? wdata1 : wdata0;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            state_d = IDLE;
            if (!cmd_we_q) begin
               if (owner_q) begin
                  rvalid1_d = 1'b1;
                  rdata1_d  = ram_rdata;
               end else begin
                  rvalid0_d = 1'b1;
                  rdata0_d  = ram_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // reset overrides the read capture of an in-flight ACCESS; the RAM write
   // itself still lands because ram_we is decoded from the current state
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         starve_cnt_q <= '0;
         cmd_we_q     <= 1'b0;
         cmd_sel_q    <= '0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         starve_cnt_q <= starve_cnt_d;
         cmd_we_q     <= cmd_we_d;
         cmd_sel_q    <= cmd_sel_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign gnt0      = (state_q == ACCESS) && !owner_q;
   assign gnt1      = (state_q == ACCESS) &&  owner_q;
   assign ram_we    = (state_q == ACCESS) &&  cmd_we_q;
   assign ram_addr  = cmd_addr_q;
   assign ram_wdata = cmd_wdata_q;
   assign ram_sel   = cmd_sel_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   typedef struct {
      bit          port;
      bit          we;
      logic [1:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gnt_exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   // fixed-priority instance
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [1:0]  sel0 = '0, sel1 = '0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
   logic [31:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
   logic [1:0]  ram_sel;

   // round-robin instance
   logic        r_req0 = 1'b0, r_req1 = 1'b0;
   logic        r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_ram_we;
   logic [31:0] r_rdata0, r_rdata1, r_ram_addr, r_ram_wdata;
   logic [31:0] r_ram_rdata = '0;
   logic [1:0]  r_ram_sel;

   int n_cmp  = 0;
   int n_fail = 0;

   gnt_exp_t    exp_gnt[$];
   logic [31:0] exp_rd0[$];
   logic [31:0] exp_rd1[$];
   bit          exp_rr[$];

   // RAM model: unwritten words read as A000_0000 + word index
   logic [31:0] mem     [0:255];
   bit          written [0:255];
   logic [7:0]  ram_idx;

   always #5 CLK = ~CLK;

   mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0), .STARVE_LIMIT(4)) u_fix (
      .CLK(CLK), .RST(RST),
      .req0(req0), .we0(we0), .sel0(sel0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .sel1(sel1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_sel(ram_sel), .ram_rdata(ram_rdata)
   );

   mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .STARVE_LIMIT(4)) u_rr (
      .CLK(CLK), .RST(RST),
      .req0(r_req0), .we0(1'b1), .sel0(2'b00), .addr0(32'h0000_0300), .wdata0(32'h0000_0C0C),
      .gnt0(r_gnt0), .rvalid0(r_rvalid0), .rdata0(r_rdata0),
      .req1(r_req1), .we1(1'b1), .sel1(2'b00), .addr1(32'h0000_0304), .wdata1(32'h0000_0D0D),
      .gnt1(r_gnt1), .rvalid1(r_rvalid1), .rdata1(r_rdata1),
      .ram_addr(r_ram_addr), .ram_wdata(r_ram_wdata), .ram_we(r_ram_we),
      .ram_sel(r_ram_sel), .ram_rdata(r_ram_rdata)
   );

   assign ram_idx   = ram_addr[9:2];
   assign ram_rdata = written[ram_idx] ? mem[ram_idx] : (32'hA000_0000 | {24'h0, ram_idx});

   always @(posedge CLK) begin
      if (ram_we) begin
         mem[ram_idx]     <= ram_wdata;
         written[ram_idx] <= 1'b1;
      end
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // scoreboard monitors, sampled on the falling edge
   bit prev_rv0 = 1'b0, prev_rv1 = 1'b0;

   always @(negedge CLK) begin
      gnt_exp_t e;
      if (gnt0 || gnt1) begin
         if (exp_gnt.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_gnt: got gnt=%b%b, expected none", gnt1, gnt0);
         end else begin
            e = exp_gnt.pop_front();
            chk("gnt_port", {30'h0, gnt1, gnt0}, e.port ? 32'h2 : 32'h1);
            chk("ram_addr", ram_addr, e.addr);
            chk("ram_we",   {31'h0, ram_we}, {31'h0, e.we});
            chk("ram_sel",  {30'h0, ram_sel}, {30'h0, e.sel});
            if (e.we) chk("ram_wdata", ram_wdata, e.wdata);
         end
      end else if (!RST) begin
         if (ram_we) chk("ram_we_idle", {31'h0, ram_we}, 32'h0);
      end
      if (rvalid0) begin
         chk("rvalid0_pulse", {31'h0, prev_rv0}, 32'h0);
         if (exp_rd0.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_rvalid0: got rdata0=%h, expected no rvalid0", rdata0);
         end else chk("rdata0", rdata0, exp_rd0.pop_front());
      end
      if (rvalid1) begin
         chk("rvalid1_pulse", {31'h0, prev_rv1}, 32'h0);
         if (exp_rd1.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_rvalid1: got rdata1=%h, expected no rvalid1", rdata1);
         end else chk("rdata1", rdata1, exp_rd1.pop_front());
      end
      prev_rv0 = rvalid0;
      prev_rv1 = rvalid1;

      if (r_gnt0 || r_gnt1) begin
         if (exp_rr.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_rr_gnt: got gnt=%b%b, expected none", r_gnt1, r_gnt0);
         end else chk("rr_gnt_port", {30'h0, r_gnt1, r_gnt0}, exp_rr.pop_front() ? 32'h2 : 32'h1);
      end
   end

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE
   // cycle after the grant, so back-to-back calls give one access per 2 cycles.
   task automatic do_access(input bit port, input bit we, input logic [1:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rexp);
      gnt_exp_t e;
      int  n;
      bit  got;
      e.port = port; e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata;
      exp_gnt.push_back(e);
      if (!we) begin
         if (port) exp_rd1.push_back(rexp);
         else      exp_rd0.push_back(rexp);
      end
      if (port) begin req1 = 1'b1; we1 = we; sel1 = sel; addr1 = addr; wdata1 = wdata; end
      else      begin req0 = 1'b1; we0 = we; sel0 = sel; addr0 = addr; wdata0 = wdata; end
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
         @(negedge CLK);
         n++;
         got = port ? gnt1 : gnt0;
      end
      chk("gnt_latency", n, 2);
      @(posedge CLK); #1;
      if (port) req1 = 1'b0; else req0 = 1'b0;
   endtask

   initial begin
      gnt_exp_t e;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         written[i] = 1'b0;
      end

      // reset with everything requesting
      RST = 1'b1; req0 = 1'b1; req1 = 1'b1; r_req0 = 1'b1; r_req1 = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_gnt0",    {31'h0, gnt0}, 32'h0);
      chk("rst_gnt1",    {31'h0, gnt1}, 32'h0);
      chk("rst_rvalid0", {31'h0, rvalid0}, 32'h0);
      chk("rst_rvalid1", {31'h0, rvalid1}, 32'h0);
      chk("rst_ram_we",  {31'h0, ram_we}, 32'h0);
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_rdata0",  rdata0, 32'h0);
      chk("rst_rdata1",  rdata1, 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0; req0 = 1'b0; req1 = 1'b0;

      // round-robin: both held from reset for exactly six accesses
      foreach (exp_rr[i]) exp_rr.delete(i);
      exp_rr.push_back(1'b0); exp_rr.push_back(1'b1); exp_rr.push_back(1'b0);
      exp_rr.push_back(1'b1); exp_rr.push_back(1'b0); exp_rr.push_back(1'b1);
      repeat (12) @(posedge CLK);
      #1; r_req0 = 1'b0; r_req1 = 1'b0;

      // port 0 write then read back
      do_access(1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
      do_access(1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF);
      do_access(1'b0, 1'b0, 2'b01, 32'h0000_0014, 32'h0,         32'hA000_0005);
      @(posedge CLK); #1;

      // fixed-priority contention, ten accesses: 0,0,0,0,1,0,0,0,0,1
      for (int i = 0; i < 10; i++) begin
         e.port  = (i == 4 || i == 9);
         e.we    = 1'b1;
         e.sel   = e.port ? 2'b10 : 2'b01;
         e.addr  = e.port ? 32'h0000_0080 : 32'h0000_0040;
         e.wdata = e.port ? 32'h0000_0B0B : 32'h0000_0A0A;
         exp_gnt.push_back(e);
      end
      req0 = 1'b1; we0 = 1'b1; sel0 = 2'b01; addr0 = 32'h0000_0040; wdata0 = 32'h0000_0A0A;
      req1 = 1'b1; we1 = 1'b1; sel1 = 2'b10; addr1 = 32'h0000_0080; wdata1 = 32'h0000_0B0B;
      repeat (20) @(posedge CLK);
      #1; req0 = 1'b0; req1 = 1'b0;
      @(negedge CLK);
      chk("contend_mem0", mem[16], 32'h0000_0A0A);
      chk("contend_mem1", mem[32], 32'h0000_0B0B);
      @(posedge CLK); #1;

      // port 1 alone, back-to-back reads
      do_access(1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0, 32'hA000_0000);
      do_access(1'b1, 1'b0, 2'b00, 32'h0000_0004, 32'h0, 32'hA000_0001);
      do_access(1'b1, 1'b0, 2'b00, 32'h0000_0008, 32'h0, 32'hA000_0002);
      chk("p1_starve_cnt", 32'(u_fix.starve_cnt_q), 32'h0);

      // reset during a port 0 read: grant seen, no rvalid, rdata0 cleared
      e.port = 1'b0; e.we = 1'b0; e.sel = 2'b00; e.addr = 32'h0000_0014; e.wdata = 32'h0;
      exp_gnt.push_back(e);
      req0 = 1'b1; we0 = 1'b0; sel0 = 2'b00; addr0 = 32'h0000_0014; wdata0 = 32'h0;
      @(posedge CLK); #1;
      RST = 1'b1; req0 = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rstacc_rvalid0", {31'h0, rvalid0}, 32'h0);
      chk("rstacc_rdata0",  rdata0, 32'h0);
      @(posedge CLK); #1;
      do_access(1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);

      // reset during a port 1 write: the write still lands
      e.port = 1'b1; e.we = 1'b1; e.sel = 2'b00; e.addr = 32'h0000_0020; e.wdata = 32'h1234_5678;
      exp_gnt.push_back(e);
      req1 = 1'b1; we1 = 1'b1; sel1 = 2'b00; addr1 = 32'h0000_0020; wdata1 = 32'h1234_5678;
      @(posedge CLK); #1;
      RST = 1'b1; req1 = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rstacc_mem",    mem[8], 32'h1234_5678);
      chk("rstacc_rdata1", rdata1, 32'h0);
      @(posedge CLK); #1;
      do_access(1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0, 32'h1234_5678);

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("left_gnt", exp_gnt.size(), 0);
      chk("left_rd0", exp_rd0.size(), 0);
      chk("left_rd1", exp_rd1.size(), 0);
      chk("left_rr",  exp_rr.size(),  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
